// File: rtl/time_keeper_register.sv
// Hours/minutes/seconds register with parallel load, set modes,
// full carry ripple, day-rollover pulse and a 12-hour view.
module time_keeper_register #(
  parameter int SEC_MOD  = 60,
  parameter int MIN_MOD  = 60,
  parameter int HOUR_MOD = 24,
  parameter int SEC_W    = 6,
  parameter int MIN_W    = 6,
  parameter int HOUR_W   = 5
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_en,
  input  logic [1:0]        i_mode,
  input  logic              i_dir,
  input  logic              i_load,
  input  logic [SEC_W-1:0]  i_load_sec,
  input  logic [MIN_W-1:0]  i_load_min,
  input  logic [HOUR_W-1:0] i_load_hour,
  output logic [SEC_W-1:0]  o_seconds,
  output logic [MIN_W-1:0]  o_minutes,
  output logic [HOUR_W-1:0] o_hours,
  output logic [HOUR_W-1:0] o_hours_12,
  output logic              o_pm,
  output logic              o_day_tick,
  output logic              o_load_err
);

  typedef enum logic [1:0] {
    MODE_COUNT    = 2'd0,
    MODE_SET_MIN  = 2'd1,
    MODE_SET_HOUR = 2'd2,
    MODE_CLR_SEC  = 2'd3
  } mode_e;

  localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(SEC_MOD - 1);
  localparam logic [MIN_W-1:0]  MIN_MAX  = MIN_W'(MIN_MOD - 1);
  localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(HOUR_MOD - 1);

  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              day_q, day_d;
  logic              err_q, err_d;

  mode_e mode;
  logic  is_count, is_set_min, is_set_hour, is_clr_sec;
  logic  sec_wrap, min_wrap, hour_wrap;
  logic  sec_ok, min_ok, hour_ok;

  assign mode        = mode_e'(i_mode);
  assign is_count    = (mode == MODE_COUNT);
  assign is_set_min  = (mode == MODE_SET_MIN);
  assign is_set_hour = (mode == MODE_SET_HOUR);
  assign is_clr_sec  = (mode == MODE_CLR_SEC);

  assign sec_wrap  = (sec_q == SEC_MAX);
  assign min_wrap  = (min_q == MIN_MAX);
  assign hour_wrap = (hour_q == HOUR_MAX);

  // Zero-extend before comparing so a modulus of 2^W still works.
  assign sec_ok  = 32'(i_load_sec) < SEC_MOD;
  assign min_ok  = 32'(i_load_min) < MIN_MOD;
  assign hour_ok = 32'(i_load_hour) < HOUR_MOD;

  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    day_d  = 1'b0;
    err_d  = 1'b0;
    if (i_load) begin
      sec_d  = sec_ok  ? i_load_sec  : '0;
      min_d  = min_ok  ? i_load_min  : '0;
      hour_d = hour_ok ? i_load_hour : '0;
      err_d  = !(sec_ok && min_ok && hour_ok);
    end else if (i_en) begin
      unique case (1'b1)
        is_count: begin
          sec_d = sec_wrap ? '0 : sec_q + 1'b1;
          if (sec_wrap) begin
            min_d = min_wrap ? '0 : min_q + 1'b1;
            if (min_wrap) begin
              hour_d = hour_wrap ? '0 : hour_q + 1'b1;
              day_d  = hour_wrap;
            end
          end
        end
        is_set_min: begin
          if (i_dir)
            min_d = (min_q == '0) ? MIN_MAX : min_q - 1'b1;
          else
            min_d = min_wrap ? '0 : min_q + 1'b1;
        end
        is_set_hour: begin
          if (i_dir)
            hour_d = (hour_q == '0) ? HOUR_MAX : hour_q - 1'b1;
          else
            hour_d = hour_wrap ? '0 : hour_q + 1'b1;
        end
        is_clr_sec: begin
          sec_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
      day_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      day_q  <= day_d;
      err_q  <= err_d;
    end
  end

  assign o_seconds  = sec_q;
  assign o_minutes  = min_q;
  assign o_hours    = hour_q;
  assign o_day_tick = day_q;
  assign o_load_err = err_q;

  generate
    if (HOUR_MOD == 24) begin : g_h12
      always_comb begin
        if (hour_q == '0)
          o_hours_12 = HOUR_W'(12);
        else if (hour_q > HOUR_W'(12))
          o_hours_12 = hour_q - HOUR_W'(12);
        else
          o_hours_12 = hour_q;
      end
      assign o_pm = (hour_q >= HOUR_W'(12));
    end else begin : g_h24
      assign o_hours_12 = hour_q;
      assign o_pm       = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_time_keeper_register.sv
// Bench for time_keeper_register: directed checks plus a randomized
// run compared against a time-of-day model on every cycle.
module tb_time_keeper_register;

  localparam int SM  = 60;
  localparam int MM  = 60;
  localparam int HM  = 24;
  localparam int DAY = SM * MM * HM;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_en = 1'b0;
  logic [1:0] i_mode = 2'd0;
  logic       i_dir = 1'b0;
  logic       i_load = 1'b0;
  logic [5:0] i_load_sec = '0;
  logic [5:0] i_load_min = '0;
  logic [4:0] i_load_hour = '0;
  logic [5:0] o_seconds;
  logic [5:0] o_minutes;
  logic [4:0] o_hours;
  logic [4:0] o_hours_12;
  logic       o_pm;
  logic       o_day_tick;
  logic       o_load_err;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  time_keeper_register dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_en        (i_en),
    .i_mode      (i_mode),
    .i_dir       (i_dir),
    .i_load      (i_load),
    .i_load_sec  (i_load_sec),
    .i_load_min  (i_load_min),
    .i_load_hour (i_load_hour),
    .o_seconds   (o_seconds),
    .o_minutes   (o_minutes),
    .o_hours     (o_hours),
    .o_hours_12  (o_hours_12),
    .o_pm        (o_pm),
    .o_day_tick  (o_day_tick),
    .o_load_err  (o_load_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int s;
    int m;
    int h;
    bit tick;
    bit err;
  } st_t;

  st_t mdl = '{0, 0, 0, 1'b0, 1'b0};

  // Counting works on seconds-of-day; set modes on the single field.
  function automatic st_t nxt(st_t c);
    st_t n;
    int t;
    n = c;
    n.tick = 1'b0;
    n.err = 1'b0;
    if (i_load) begin
      n.s = (int'(i_load_sec) < SM) ? int'(i_load_sec) : 0;
      n.m = (int'(i_load_min) < MM) ? int'(i_load_min) : 0;
      n.h = (int'(i_load_hour) < HM) ? int'(i_load_hour) : 0;
      n.err = (int'(i_load_sec) >= SM) || (int'(i_load_min) >= MM)
           || (int'(i_load_hour) >= HM);
    end else if (i_en) begin
      case (i_mode)
        2'd0: begin
          t = (c.h * MM + c.m) * SM + c.s;
          t = (t + 1) % DAY;
          n.tick = (t == 0);
          n.s = t % SM;
          n.m = (t / SM) % MM;
          n.h = t / (SM * MM);
        end
        2'd1: n.m = (c.m + (i_dir ? MM - 1 : 1)) % MM;
        2'd2: n.h = (c.h + (i_dir ? HM - 1 : 1)) % HM;
        default: n.s = 0;
      endcase
    end
    return n;
  endfunction

  function automatic int h12(int h);
    return (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
  endfunction

  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) mdl <= '{0, 0, 0, 1'b0, 1'b0};
    else mdl <= nxt(mdl);
  end

  task automatic cmp(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (chk_on) begin
      cmp("m_sec",  int'(o_seconds),  mdl.s);
      cmp("m_min",  int'(o_minutes),  mdl.m);
      cmp("m_hour", int'(o_hours),    mdl.h);
      cmp("m_h12",  int'(o_hours_12), h12(mdl.h));
      cmp("m_pm",   int'(o_pm),       int'(mdl.h >= 12));
      cmp("m_day",  int'(o_day_tick), int'(mdl.tick));
      cmp("m_err",  int'(o_load_err), int'(mdl.err));
    end
  end

  task automatic step(input bit en, input int mode, input bit dir,
                      input bit ld, input int ls, input int lm,
                      input int lh);
    i_en = en;
    i_mode = 2'(mode);
    i_dir = dir;
    i_load = ld;
    i_load_sec = 6'(ls);
    i_load_min = 6'(lm);
    i_load_hour = 5'(lh);
    @(posedge i_clk);
    #1;
    i_en = 1'b0;
    i_load = 1'b0;
  endtask

  task automatic load(input int s, input int m, input int h);
    step(1'b0, 0, 1'b0, 1'b1, s, m, h);
  endtask

  task automatic tick(input int mode, input bit dir);
    step(1'b1, mode, dir, 1'b0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    chk_on = 1'b1;
    #1;
    cmp("rst_sec", int'(o_seconds), 0);
    cmp("rst_min", int'(o_minutes), 0);
    cmp("rst_hour", int'(o_hours), 0);
    cmp("rst_h12", int'(o_hours_12), 12);
    cmp("rst_pm", int'(o_pm), 0);
    cmp("rst_day", int'(o_day_tick), 0);
    cmp("rst_err", int'(o_load_err), 0);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;

    repeat (61) tick(0, 1'b0);
    cmp("cnt61_sec", int'(o_seconds), 1);
    cmp("cnt61_min", int'(o_minutes), 1);
    cmp("cnt61_hour", int'(o_hours), 0);
    cmp("cnt61_h12", int'(o_hours_12), 12);

    load(59, 59, 23);
    cmp("ld_noday", int'(o_day_tick), 0);
    cmp("ld_hour", int'(o_hours), 23);
    tick(0, 1'b0);
    cmp("roll_sec", int'(o_seconds), 0);
    cmp("roll_min", int'(o_minutes), 0);
    cmp("roll_hour", int'(o_hours), 0);
    cmp("roll_day", int'(o_day_tick), 1);
    step(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
    cmp("roll_day_off", int'(o_day_tick), 0);

    tick(1, 1'b1);
    cmp("smin_dn", int'(o_minutes), 59);
    cmp("smin_dn_h", int'(o_hours), 0);
    tick(1, 1'b0);
    cmp("smin_up", int'(o_minutes), 0);
    cmp("smin_up_h", int'(o_hours), 0);

    load(0, 0, 12);
    tick(2, 1'b0);
    tick(2, 1'b0);
    cmp("shr_hour", int'(o_hours), 14);
    cmp("shr_h12", int'(o_hours_12), 2);
    cmp("shr_pm", int'(o_pm), 1);
    load(0, 0, 23);
    tick(2, 1'b0);
    cmp("shr_wrap", int'(o_hours), 0);
    cmp("shr_noday", int'(o_day_tick), 0);

    load(60, 5, 30);
    cmp("clamp_sec", int'(o_seconds), 0);
    cmp("clamp_min", int'(o_minutes), 5);
    cmp("clamp_hour", int'(o_hours), 0);
    cmp("clamp_err", int'(o_load_err), 1);
    step(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
    cmp("clamp_err_off", int'(o_load_err), 0);
    step(1'b1, 0, 1'b0, 1'b1, 3, 2, 1);
    cmp("ldwin_sec", int'(o_seconds), 3);
    cmp("ldwin_err", int'(o_load_err), 0);

    load(45, 20, 10);
    tick(3, 1'b0);
    cmp("clr_sec", int'(o_seconds), 0);
    cmp("clr_min", int'(o_minutes), 20);
    cmp("clr_hour", int'(o_hours), 10);

    load(59, 59, 23);
    i_en = 1'b1;
    i_mode = 2'd0;
    @(posedge i_clk);
    #2;
    cmp("pend_day", int'(o_day_tick), 1);
    i_reset_n = 1'b0;
    #1;
    cmp("arst_day", int'(o_day_tick), 0);
    cmp("arst_sec", int'(o_seconds), 0);
    cmp("arst_hour", int'(o_hours), 0);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    i_en = 1'b0;
    repeat (5) tick(0, 1'b0);
    cmp("resume_sec", int'(o_seconds), 5);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 3) == 0)
          step($urandom_range(0, 1) == 1, $urandom_range(0, 3), 1'b0,
               1'b1, $urandom_range(55, 59), 59, 23);
        else
          step($urandom_range(0, 1) == 1, $urandom_range(0, 3), 1'b0,
               1'b1, $urandom_range(0, 63), $urandom_range(0, 63),
               $urandom_range(0, 31));
      end else begin
        step($urandom_range(0, 1) == 1,
             ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 3),
             $urandom_range(0, 1) == 1, 1'b0, 0, 0, 0);
      end
    end

    @(negedge i_clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
